// File: rtl/frac_clock_divider.sv
// rtl/frac_clock_divider.sv - fractional-N clock divider built on a phase accumulator
// clkout is the registered accumulator MSB; tick pulses on every accumulator wrap.
module frac_clock_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clkin,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] div,
    output logic             clkout,
    output logic             tick
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH:0]   sum_full;
    logic             carry;
    logic             load_div;

    assign sum_full = {1'b0, acc} + {1'b0, div_act};
    assign carry    = sum_full[WIDTH];

    // New rates are taken only at a period boundary so clkout never gets a
    // runt phase; an idle (zero) rate picks up div immediately.
    assign load_div = carry || (div_act == '0);

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            div_act <= '0;
            clkout  <= 1'b0;
            tick    <= 1'b0;
        end else begin
            acc    <= sum_full[WIDTH-1:0];
            tick   <= carry;
            clkout <= acc[WIDTH-1];
            if (load_div) begin
                div_act <= div;
            end
        end
    end

endmodule

// File: tb/tb_frac_clock_divider.sv
// tb/tb_frac_clock_divider.sv - randomized self-checking bench for frac_clock_divider
module tb_frac_clock_divider;

    localparam int W = 32;

    logic         clkin   = 1'b0;
    logic         reset_n = 1'b1;
    logic [W-1:0] div     = '0;
    logic         clkout;
    logic         tick;

    int n_cmp = 0;
    int n_err = 0;

    frac_clock_divider #(.WIDTH(W)) dut (
        .clkin   (clkin),
        .reset_n (reset_n),
        .div     (div),
        .clkout  (clkout),
        .tick    (tick)
    );

    always #5 clkin = ~clkin;

    // Reference: total phase as an unbounded integer; acc is its low W bits,
    // each wrap is a change in the integer part of phase/2^W.
    longint unsigned m_phase = 0;
    longint unsigned m_rate  = 0;
    logic            m_clk   = 1'b0;
    logic            m_tick  = 1'b0;

    always @(posedge clkin or negedge reset_n) begin
        longint unsigned prev;
        if (!reset_n) begin
            m_phase = 0;
            m_rate  = 0;
            m_clk   = 1'b0;
            m_tick  = 1'b0;
        end else begin
            prev    = m_phase;
            m_phase = prev + m_rate;
            m_clk   = ((prev >> (W - 1)) & 64'd1) != 0;
            m_tick  = (m_phase >> W) != (prev >> W);
            if (m_tick || m_rate == 0) m_rate = longint'(div);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic chk_en = 1'b0;

    always @(negedge clkin) begin
        if (chk_en) begin
            check("clkout", {63'd0, clkout}, {63'd0, m_clk});
            check("tick", {63'd0, tick}, {63'd0, m_tick});
            check("acc", {32'd0, dut.acc}, {32'd0, m_phase[W-1:0]});
        end
    end

    task automatic do_reset(input logic [W-1:0] d);
        @(negedge clkin);
        reset_n = 1'b0;
        div     = d;
        @(negedge clkin);
        reset_n = 1'b1;
    endtask

    task automatic capture(input int n, output logic [31:0] cs, output logic [31:0] ts);
        cs = '0;
        ts = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clkin);
            cs[i] = clkout;
            ts[i] = tick;
        end
    endtask

    task automatic count_edges(input logic [W-1:0] d, input int n, input string name);
        int      rises;
        logic    prev;
        longint  expv;
        longint  diff;
        do_reset(d);
        @(negedge clkin);
        @(negedge clkin);
        prev  = clkout;
        rises = 0;
        for (int i = 1; i < n; i++) begin
            @(negedge clkin);
            if (!prev && clkout) rises++;
            prev = clkout;
        end
        expv = (longint'(n) * longint'(d)) >>> W;
        diff = longint'(rises) - expv;
        n_cmp++;
        if (diff > 1 || diff < -1) begin
            n_err++;
            $display("FAIL %s: got %0d rising edges expected %0d +-1", name, rises, expv);
        end
    endtask

    task automatic async_reset_check();
        @(posedge clkin);
        #($urandom_range(1, 4));
        reset_n = 1'b0;
        #1;
        check("async_clkout", {63'd0, clkout}, 64'd0);
        check("async_tick", {63'd0, tick}, 64'd0);
        check("async_acc", {32'd0, dut.acc}, 64'd0);
        check("async_div_act", {32'd0, dut.div_act}, 64'd0);
        @(negedge clkin);
        reset_n = 1'b1;
    endtask

    logic [31:0] cs;
    logic [31:0] ts;

    initial begin
        #1 reset_n = 1'b0;
        @(negedge clkin);
        @(negedge clkin);
        check("reset_clkout", {63'd0, clkout}, 64'd0);
        check("reset_tick", {63'd0, tick}, 64'd0);
        check("reset_acc", {32'd0, dut.acc}, 64'd0);
        chk_en = 1'b1;

        // quarter-rate pattern straight out of reset
        do_reset(32'h4000_0000);
        capture(9, cs, ts);
        check("t1_clkout", {55'd0, cs[8:0]}, 64'b110011000);
        check("t1_tick", {55'd0, ts[8:0]}, 64'b100010000);

        // half rate
        do_reset(32'h8000_0000);
        capture(6, cs, ts);
        check("t2_clkout", {58'd0, cs[5:0]}, 64'b010100);
        check("t2_tick", {58'd0, ts[5:0]}, 64'b010100);

        // rate change mid-period only takes effect at the next wrap
        do_reset(32'h4000_0000);
        repeat (6) @(negedge clkin);
        div = 32'h8000_0000;
        capture(8, cs, ts);
        check("t4_clkout", {56'd0, cs[7:0]}, 64'b01010110);
        check("t4_tick", {56'd0, ts[7:0]}, 64'b01010100);

        // zero rate holds everything, then a nonzero rate loads on the next edge
        do_reset(32'h0);
        capture(20, cs, ts);
        check("t5_idle_clkout", {32'd0, cs}, 64'd0);
        check("t5_idle_tick", {32'd0, ts}, 64'd0);
        div = 32'h4000_0000;
        capture(9, cs, ts);
        check("t5_clkout", {55'd0, cs[8:0]}, 64'b110011000);
        check("t5_tick", {55'd0, ts[8:0]}, 64'b100010000);

        // asynchronous reset in the middle of a period
        do_reset(32'h4000_0000);
        repeat (5) @(negedge clkin);
        async_reset_check();
        capture(9, cs, ts);
        check("t6_clkout", {55'd0, cs[8:0]}, 64'b110011000);
        check("t6_tick", {55'd0, ts[8:0]}, 64'b100010000);

        // average frequency of the NTSC and PAL words
        count_edges(32'd922441723, 30000, "ntsc_edges");
        count_edges(32'd914027882, 30000, "pal_edges");

        // random rate changes, zero rates and asynchronous resets
        for (int it = 0; it < 40; it++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                async_reset_check();
            end else begin
                @(negedge clkin);
                if (sel == 1) div = '0;
                else if (sel == 2) div = W'($urandom_range(1, 4096)) << 20;
                else div = $urandom;
            end
            repeat ($urandom_range(5, 200)) @(negedge clkin);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
